alu_arbiter: RTL and testbench

Shares one combinational alu datapath between N_REQ independent requesters. Each requester uses a valid/ready request channel. Grants are round-robin. The block latches the granted operands, holds them on the alu for the required number of cycles, then returns a registered, tagged result on a single valid/ready response channel. It sits between the alu instance and the client blocks that issue arithmetic/logic operations.

---
 rtl/alu_ctrl_pkg.sv | 33 +++
 rtl/alu.sv | 50 +++++
 rtl/rr_arbiter.sv | 39 +++
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU arbiter slice: opcode encodings, FSM state
// encoding, EXEC counter width and a helper that gives the number of EXEC
// cycles an opcode needs.
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam int OP_W  = 3;
  localparam int CNT_W = 4;   // holds MUL_LAT up to 15

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL  = 3'b010;
  localparam logic [OP_W-1:0] OP_RAND = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  // Number of cycles an operation spends in EXEC.
  function automatic logic [CNT_W-1:0] exec_cycles(input logic [OP_W-1:0] op,
                                                   input int mul_lat);
    if (op == OP_MUL) return CNT_W'(mul_lat);
    return CNT_W'(1);
  endfunction

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU with a 64-bit result and flags.
// Ports:
//   a, b       32-bit operands
//   op         3-bit opcode (see alu_ctrl_pkg)
//   result     64-bit result; non-multiply results are zero-extended 32-bit
//   sign_flag  result[63]
//   zero_flag  result == 0
// Opcode 100 is not defined and yields zero.
// -----------------------------------------------------------------------------
module alu
  import alu_ctrl_pkg::*;
(
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  input  logic [OP_W-1:0] op,
  output logic [63:0]     result,
  output logic            sign_flag,
  output logic            zero_flag
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] shl;
  logic [31:0] shr;

  assign sum  = a + b;
  assign diff = a - b;
  assign shl  = a << b[4:0];
  assign shr  = a >> b[4:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = {32'h0, sum};
      OP_SUB:  result = {32'h0, diff};
      OP_MUL:  result = {32'h0, a} * {32'h0, b};
      OP_RAND: result = {63'h0, &a};
      OP_XOR:  result = {32'h0, a ^ b};
      OP_SHL:  result = {32'h0, shl};
      OP_SHR:  result = {32'h0, shr};
      default: result = '0;
    endcase
  end

  assign sign_flag = result[63];
  assign zero_flag = (result == 64'h0);

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant: picks the first asserted request at or
// above rr_ptr, wrapping at N_REQ.
// Ports:
//   req        request vector
//   rr_ptr     highest-priority index
//   grant      one-hot grant (zero when no request)
//   grant_idx  index of the granted request (0 when no request)
//   any_req    at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_req
);

  always_comb begin : search
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    idx       = 0;
    // Walk from the farthest candidate back to rr_ptr so the nearest hit
    // (closest to rr_ptr) is the one left standing.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) grant_idx = ID_W'(idx);
    end
    if (any_req) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between N_REQ requesters. A round-robin grant in IDLE latches
// the winner's operands, EXEC holds them on the ALU for the opcode's latency,
// and RESP presents a registered, tagged result until it is accepted.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no operation in flight; grant one pending request
//   S_EXEC | operands held on the ALU, counting latency cycles
//   S_RESP | result registered, rsp_valid high until rsp_ready
//
// Ports:
//   clk, rst_n                clock, async active-low reset
//   req_valid/req_ready       per-requester handshake (ready one-hot or zero)
//   req_a, req_b, req_op      packed per-requester operands / opcode
//   rsp_valid/rsp_ready       response handshake
//   rsp_out, rsp_sign,
//   rsp_zero, rsp_id          registered result, flags and requester tag
//   busy                      high whenever not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ID_W    = 1,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*32-1:0]  req_a,
  input  logic [N_REQ*32-1:0]  req_b,
  input  logic [N_REQ*3-1:0]   req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [63:0]          rsp_out,
  output logic                 rsp_sign,
  output logic                 rsp_zero,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [OP_W-1:0]   op_code;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  exec_last;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              any_req;

  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic [OP_W-1:0]   sel_op;

  logic [63:0]       alu_result;
  logic              alu_sign;
  logic              alu_zero;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // The ALU only ever sees the latched operands, never the live request bus.
  alu u_alu (
    .a         (op_a),
    .b         (op_b),
    .op        (op_code),
    .result    (alu_result),
    .sign_flag (alu_sign),
    .zero_flag (alu_zero)
  );

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
        sel_op = req_op[3*i +: 3];
      end
    end
  end

  // Ready is only offered from IDLE; gating with rst_n keeps it low while
  // reset is held even if requesters are already asserting valid.
  assign req_ready = (rst_n && (state == S_IDLE)) ? grant : '0;
  assign busy      = (state != S_IDLE);
  assign exec_last = exec_cycles(op_code, MUL_LAT) - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_sign  <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // any_req in IDLE means the granted requester sees ready this cycle.
          if (any_req) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            op_code <= sel_op;
            rsp_id  <= grant_idx;
            cnt     <= '0;
            if (int'(grant_idx) == N_REQ - 1) rr_ptr <= '0;
            else                              rr_ptr <= grant_idx + 1'b1;
            state   <= S_EXEC;
          end
        end

        S_EXEC: begin
          cnt <= cnt + 1'b1;
          if (cnt == exec_last) begin
            rsp_out   <= alu_result;
            rsp_sign  <= alu_sign;
            rsp_zero  <= alu_zero;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Scoreboard bench for alu_arbiter (N_REQ=2, MUL_LAT=3). Tests push
// hand-computed responses into a queue; a monitor pops and compares whenever
// a response is accepted.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int N       = 2;
  localparam int IDW     = 1;
  localparam int MUL_LAT = 3;

  localparam logic [2:0] C_ADD = 3'b000;
  localparam logic [2:0] C_SUB = 3'b001;
  localparam logic [2:0] C_MUL = 3'b010;
  localparam logic [2:0] C_RAN = 3'b011;
  localparam logic [2:0] C_UND = 3'b100;
  localparam logic [2:0] C_XOR = 3'b101;
  localparam logic [2:0] C_SHL = 3'b110;
  localparam logic [2:0] C_SHR = 3'b111;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a;
  logic [N*32-1:0]   req_b;
  logic [N*3-1:0]    req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_out;
  logic              rsp_sign;
  logic              rsp_zero;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  alu_arbiter #(
    .N_REQ   (N),
    .ID_W    (IDW),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_sign  (rsp_sign),
    .rsp_zero  (rsp_zero),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] out;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   hs_cnt[N];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(input int id, input logic [63:0] out);
    exp_t e;
    e.id  = id;
    e.out = out;
    sb.push_back(e);
  endfunction

  // Handshake recorder (sampled before the DUT's registers update).
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hs_cnt[i]++;
          grant_log.push_back(i);
        end
      end
    end
  end

  // Stimulus protocol check: a pending, unaccepted request must stay put.
  logic [N-1:0]    pv = '0;
  logic [N-1:0]    pr = '0;
  logic [N*32-1:0] pa = '0;
  logic [N*32-1:0] pb = '0;
  logic [N*3-1:0]  po = '0;
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (pv[i] && !pr[i]) begin
          if (!req_valid[i] || req_a[32*i +: 32] != pa[32*i +: 32] ||
              req_b[32*i +: 32] != pb[32*i +: 32] || req_op[3*i +: 3] != po[3*i +: 3]) begin
            n_fail++;
            $display("FAIL proto req%0d: request withdrawn or changed before ready", i);
          end
        end
      end
    end
    pv = rst_n ? req_valid : '0;
    pr = req_ready;
    pa = req_a;
    pb = req_b;
    po = req_op;
  end

  // Monitor: compare every accepted response against the scoreboard head.
  always @(negedge clk) begin
    #1;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got out=%0h id=%0d with nothing expected", rsp_out, rsp_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id",   64'(rsp_id),   64'(e.id));
        chk("rsp_out",  rsp_out,       e.out);
        chk("rsp_sign", 64'(rsp_sign), 64'(e.out[63]));
        chk("rsp_zero", 64'(rsp_zero), 64'(e.out == 64'h0));
      end
    end
  end

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    int start;
    bit done;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3]  = op;
    req_valid[i]      = 1'b1;
    start = hs_cnt[i];
    done  = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (hs_cnt[i] != start) done = 1'b1;
    end
    req_valid[i] = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL issue_timeout req%0d: got no grant, expected one within 300 cycles", i);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    // let the consuming edge of the last response pass
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int          rq;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 32'h0000DEAD, 32'h1,        C_UND, 64'h0};
    vecs[1] = '{1, 32'hFFFFFFFF, 32'h0,        C_RAN, 64'h1};
    vecs[2] = '{0, 32'h0F0F0F0F, 32'hFFFF0000, C_XOR, 64'hF0F00F0F};
    vecs[3] = '{1, 32'h80000001, 32'd33,       C_SHL, 64'h2};
    vecs[4] = '{0, 32'h80000000, 32'd31,       C_SHR, 64'h1};
    vecs[5] = '{1, 32'h0,        32'h1,        C_SUB, 64'hFFFFFFFF};
    vecs[6] = '{0, 32'hFFFFFFFF, 32'h1,        C_ADD, 64'h0};
    vecs[7] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, C_MUL, 64'hFFFFFFFE00000001};
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin : main
    int busy_cnt;
    int first_valid;
    int stale;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) hs_cnt[i] = 0;

    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_busy",      64'(busy),      64'h0);
    chk("rst_rsp_out",   rsp_out,        64'h0);
    chk("rst_rsp_sign",  64'(rsp_sign),  64'h0);
    chk("rst_rsp_zero",  64'(rsp_zero),  64'h0);
    chk("rst_rsp_id",    64'(rsp_id),    64'h0);
    chk("rst_rr_ptr",    64'(dut.rr_ptr), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single add: response visible after the second edge.
    push_exp(0, 64'd12);
    issue(0, 32'd5, 32'd7, C_ADD);
    chk("add_valid_after_e0", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    chk("add_valid_after_e1", 64'(rsp_valid), 64'h1);
    drain();

    // Multiply latency and busy window.
    push_exp(1, 64'h1_FFFFFFFE);
    issue(1, 32'hFFFFFFFF, 32'd2, C_MUL);
    busy_cnt    = 0;
    first_valid = -1;
    for (int k = 0; k < 8; k++) begin
      if (busy) busy_cnt++;
      if (rsp_valid && first_valid < 0) first_valid = k;
      @(negedge clk);
    end
    chk("mul_busy_cycles", 64'(busy_cnt), 64'd4);
    chk("mul_first_valid", 64'(first_valid), 64'd3);
    chk("mul_rr_wrap",     64'(dut.rr_ptr), 64'h0);
    drain();

    // Fairness: both requesters keep a request pending.
    grant_log.delete();
    push_exp(0, 64'd1);
    push_exp(1, 64'd2);
    push_exp(0, 64'd3);
    push_exp(1, 64'd4);
    fork
      begin
        issue(0, 32'd0, 32'd1, C_ADD);
        issue(0, 32'd2, 32'd1, C_ADD);
      end
      begin
        issue(1, 32'd1, 32'd1, C_ADD);
        issue(1, 32'd3, 32'd1, C_ADD);
      end
    join
    drain();
    chk("fair_grants", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < grant_log.size() && k < 4; k++)
      chk($sformatf("fair_grant_%0d", k), 64'(grant_log[k]), 64'(k % 2));
    chk("fair_rr_ptr", 64'(dut.rr_ptr), 64'h0);

    // Backpressure with a second request waiting.
    rsp_ready = 1'b0;
    push_exp(0, 64'h0);
    push_exp(1, 64'd30);
    issue(0, 32'd3, 32'd3, C_SUB);
    fork
      issue(1, 32'd10, 32'd20, C_ADD);
      begin
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          chk("bp_valid_held", 64'(rsp_valid), 64'h1);
          chk("bp_out_stable", rsp_out,        64'h0);
          chk("bp_zero",       64'(rsp_zero),  64'h1);
          chk("bp_no_ready",   64'(req_ready), 64'h0);
          @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_regrant_ready", 64'(req_ready), 64'h2);
        chk("bp_valid_drop",    64'(rsp_valid), 64'h0);
      end
    join
    drain();

    // Directed operation vectors, alternating requesters.
    for (int v = 0; v < 8; v++) begin
      push_exp(vecs[v].rq, vecs[v].exp);
      issue(vecs[v].rq, vecs[v].a, vecs[v].b, vecs[v].op);
    end
    drain();

    // Reset in the middle of a multiply.
    issue(0, 32'd3, 32'd4, C_MUL);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid),  64'h0);
    chk("mid_rst_busy",      64'(busy),       64'h0);
    chk("mid_rst_rr_ptr",    64'(dut.rr_ptr), 64'h0);
    chk("mid_rst_rsp_out",   rsp_out,         64'h0);
    chk("mid_rst_rsp_id",    64'(rsp_id),     64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("no_stale_rsp", 64'(stale), 64'h0);
    push_exp(1, 64'd123);
    issue(1, 32'd100, 32'd23, C_ADD);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
